// File: rtl/fetch_queue_if.sv
// Instruction-memory port of the fetch unit: one outstanding request,
// one-cycle response pulse.
interface fetch_queue_if;
    logic        im_req_valid;
    logic [31:0] im_req_addr;
    logic        im_req_ready;
    logic        im_resp_valid;
    logic [31:0] im_resp_data;

    modport master (
        output im_req_valid, im_req_addr,
        input  im_req_ready, im_resp_valid, im_resp_data
    );

    modport slave (
        input  im_req_valid, im_req_addr,
        output im_req_ready, im_resp_valid, im_resp_data
    );
endinterface

// File: rtl/fetch_queue.sv
// Decoupled instruction fetch: single outstanding memory request feeding a
// DEPTH-entry instruction/PC queue whose head is presented to decode.
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000,
    parameter int          DEPTH    = 4
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       STALL,
    input  logic                       Request_Alt_PC,
    input  logic [31:0]                Alt_PC,
    fetch_queue_if.master              im,
    output logic [31:0]                Instr1_OUT,
    output logic [31:0]                Instr_PC_OUT,
    output logic [31:0]                Instr_PC_Plus4,
    output logic                       out_valid,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   fetch_pc_reg;
    logic [31:0]   req_pc_reg;
    logic          busy_reg;
    logic          drop_reg;
    logic [PW-1:0] head_reg;
    logic [PW-1:0] tail_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic [31:0]   instr_mem_reg [DEPTH];
    logic [31:0]   pc_mem_reg    [DEPTH];

    logic not_empty;
    logic issue;
    logic accept;
    logic resp;
    logic enq;
    logic deq;

    assign not_empty = (count_reg != '0);

    // Issue only when the queue has room for the answer, so an outstanding
    // request always owns a free slot. Gated by RESET so outputs read 0 in reset.
    assign issue  = RESET && !busy_reg && (count_reg != CW'(DEPTH)) && !Request_Alt_PC;
    assign accept = issue && im.im_req_ready;
    assign resp   = im.im_resp_valid && busy_reg;
    assign enq    = resp && !drop_reg && !Request_Alt_PC;
    assign deq    = not_empty && !STALL && !Request_Alt_PC;

    assign im.im_req_valid = issue;
    assign im.im_req_addr  = RESET ? fetch_pc_reg : 32'd0;

    always_comb begin
        count_next = count_reg;
        case ({enq, deq})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            fetch_pc_reg <= RESET_PC;
            req_pc_reg   <= '0;
            busy_reg     <= 1'b0;
            drop_reg     <= 1'b0;
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
        end else if (Request_Alt_PC) begin
            fetch_pc_reg <= Alt_PC;
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            // A response racing the redirect is simply consumed; otherwise
            // the still-outstanding one must be thrown away when it lands.
            if (resp) begin
                busy_reg <= 1'b0;
                drop_reg <= 1'b0;
            end else if (busy_reg) begin
                drop_reg <= 1'b1;
            end
        end else begin
            if (accept) begin
                busy_reg     <= 1'b1;
                req_pc_reg   <= fetch_pc_reg;
                fetch_pc_reg <= fetch_pc_reg + 32'd4;
            end else if (resp) begin
                busy_reg <= 1'b0;
                drop_reg <= 1'b0;
            end
            if (enq) tail_reg <= tail_reg + PW'(1);
            if (deq) head_reg <= head_reg + PW'(1);
            count_reg <= count_next;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_reg[i] <= '0;
                pc_mem_reg[i]    <= '0;
            end
        end else if (enq) begin
            instr_mem_reg[tail_reg] <= im.im_resp_data;
            pc_mem_reg[tail_reg]    <= req_pc_reg;
        end
    end

    assign out_valid      = not_empty;
    assign occupancy      = count_reg;
    assign Instr1_OUT     = not_empty ? instr_mem_reg[head_reg] : 32'd0;
    assign Instr_PC_OUT   = not_empty ? pc_mem_reg[head_reg] : 32'd0;
    assign Instr_PC_Plus4 = not_empty ? pc_mem_reg[head_reg] + 32'd4 : 32'd0;
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: latency-programmable memory responder, queue-based
// reference model checked every cycle, and directed scenarios with literal checks.
module tb_fetch_queue;
    localparam logic [31:0] RESET_PC_C = 32'hBFC00000;
    localparam int          DEPTH_C    = 4;
    localparam logic [31:0] KEY        = 32'h12345678;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        STALL;
    logic        Request_Alt_PC;
    logic [31:0] Alt_PC;
    logic [31:0] Instr1_OUT;
    logic [31:0] Instr_PC_OUT;
    logic [31:0] Instr_PC_Plus4;
    logic        out_valid;
    logic [2:0]  occupancy;

    fetch_queue_if mif();

    fetch_queue #(.RESET_PC(RESET_PC_C), .DEPTH(DEPTH_C)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .STALL          (STALL),
        .Request_Alt_PC (Request_Alt_PC),
        .Alt_PC         (Alt_PC),
        .im             (mif),
        .Instr1_OUT     (Instr1_OUT),
        .Instr_PC_OUT   (Instr_PC_OUT),
        .Instr_PC_Plus4 (Instr_PC_Plus4),
        .out_valid      (out_valid),
        .occupancy      (occupancy)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int lat   = 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    // Memory: captures an accepted request and answers it lat cycles later.
    initial begin
        logic        acc;
        logic [31:0] a;
        logic [31:0] paddr;
        int          cd;
        cd = 0;
        paddr = '0;
        mif.im_resp_valid = 1'b0;
        mif.im_resp_data  = '0;
        forever begin
            @(posedge CLK);
            acc = mif.im_req_valid && mif.im_req_ready;
            a   = mif.im_req_addr;
            #1;
            mif.im_resp_valid = 1'b0;
            if (acc) begin
                paddr = a;
                cd    = lat;
                $display("req  addr=%h latency=%0d", a, lat);
            end
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    mif.im_resp_valid = 1'b1;
                    mif.im_resp_data  = paddr ^ KEY;
                    $display("resp addr=%h data=%h", paddr, paddr ^ KEY);
                end
            end
        end
    end

    // Reference model: the queue is a plain SV queue of {instr, pc}.
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_fpc  = RESET_PC_C;
    logic [31:0] m_ppc  = '0;
    bit          m_pend = 1'b0;
    bit          m_drop = 1'b0;

    function automatic bit exp_req_valid();
        return RESET && !m_pend && (mq.size() < DEPTH_C) && !Request_Alt_PC;
    endfunction

    initial begin
        forever begin
            @(posedge CLK or negedge RESET);
            if (!RESET) begin
                mq.delete();
                m_fpc  = RESET_PC_C;
                m_pend = 1'b0;
                m_drop = 1'b0;
            end else begin
                bit ev;
                bit rv;
                ev = exp_req_valid();
                rv = mif.im_resp_valid && m_pend;
                if (Request_Alt_PC) begin
                    mq.delete();
                    m_fpc = Alt_PC;
                    if (rv) begin
                        m_pend = 1'b0;
                        m_drop = 1'b0;
                    end else if (m_pend) begin
                        m_drop = 1'b1;
                    end
                end else begin
                    if (mq.size() != 0 && !STALL) void'(mq.pop_front());
                    if (rv) begin
                        if (!m_drop) mq.push_back('{instr: mif.im_resp_data, pc: m_ppc});
                        m_pend = 1'b0;
                        m_drop = 1'b0;
                    end
                    if (ev && mif.im_req_ready) begin
                        m_pend = 1'b1;
                        m_ppc  = m_fpc;
                        m_fpc  = m_fpc + 32'd4;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge CLK);
            chk("m_out_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
            chk("m_occupancy", {29'd0, occupancy}, mq.size());
            chk("m_instr", Instr1_OUT, (mq.size() != 0) ? mq[0].instr : 32'd0);
            chk("m_pc", Instr_PC_OUT, (mq.size() != 0) ? mq[0].pc : 32'd0);
            chk("m_pc_plus4", Instr_PC_Plus4, (mq.size() != 0) ? mq[0].pc + 32'd4 : 32'd0);
            chk("m_req_valid", {31'd0, mif.im_req_valid}, {31'd0, exp_req_valid()});
            chk("m_req_addr", mif.im_req_addr, RESET ? m_fpc : 32'd0);
        end
    end

    task automatic wait_req(input string nm, input int max);
        bit ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            if (mif.im_req_valid) ok = 1'b1;
            else tick();
        end
        chk(nm, {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_out(input string nm, input int max);
        bit ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            if (out_valid) ok = 1'b1;
            else tick();
        end
        chk(nm, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        bit found;
        RESET = 1'b0;
        STALL = 1'b0;
        Request_Alt_PC = 1'b0;
        Alt_PC = '0;
        mif.im_req_ready = 1'b1;
        repeat (3) tick();

        // Reset state
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_occupancy", {29'd0, occupancy}, 32'd0);
        chk("rst_pc", Instr_PC_OUT, 32'd0);
        chk("rst_req_valid", {31'd0, mif.im_req_valid}, 32'd0);
        chk("rst_req_addr", mif.im_req_addr, 32'd0);

        // Streaming at latency 1
        RESET = 1'b1;
        #1;
        chk("first_req_valid", {31'd0, mif.im_req_valid}, 32'd1);
        chk("first_req_addr", mif.im_req_addr, 32'hBFC00000);
        tick();
        tick();
        chk("e0_pc", Instr_PC_OUT, 32'hBFC00000);
        chk("e0_plus4", Instr_PC_Plus4, 32'hBFC00004);
        chk("e0_instr", Instr1_OUT, 32'hADF45678);
        chk("req1_addr", mif.im_req_addr, 32'hBFC00004);
        tick();
        chk("gap_out_valid", {31'd0, out_valid}, 32'd0);
        chk("gap_req_valid", {31'd0, mif.im_req_valid}, 32'd0);
        tick();
        chk("e1_pc", Instr_PC_OUT, 32'hBFC00004);
        chk("req2_addr", mif.im_req_addr, 32'hBFC00008);

        // Decode stall fills the queue
        STALL = 1'b1;
        repeat (10) tick();
        chk("full_occupancy", {29'd0, occupancy}, 32'd4);
        chk("full_req_valid", {31'd0, mif.im_req_valid}, 32'd0);
        chk("full_head_pc", Instr_PC_OUT, 32'hBFC00004);
        STALL = 1'b0;
        tick();
        chk("drain_head_pc", Instr_PC_OUT, 32'hBFC00008);
        chk("resume_req_addr", mif.im_req_addr, 32'hBFC00014);
        repeat (12) tick();

        // Redirect while a request is outstanding
        lat = 3;
        wait_req("wait_req_pre_redirect", 20);
        tick();
        Request_Alt_PC = 1'b1;
        Alt_PC = 32'h80000100;
        tick();
        Request_Alt_PC = 1'b0;
        #1;
        chk("redir_occupancy", {29'd0, occupancy}, 32'd0);
        chk("redir_out_valid", {31'd0, out_valid}, 32'd0);
        chk("redir_req_valid", {31'd0, mif.im_req_valid}, 32'd0);
        wait_req("wait_req_alt", 20);
        chk("alt_req_addr", mif.im_req_addr, 32'h80000100);
        wait_out("wait_out_alt", 20);
        chk("alt_head_pc", Instr_PC_OUT, 32'h80000100);
        chk("alt_head_instr", Instr1_OUT, 32'h92345778);

        // Redirect coinciding with a response and a dequeue, to a wrapping PC
        lat = 1;
        STALL = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (occupancy >= 3'd2 && mif.im_resp_valid) found = 1'b1;
        end
        chk("find_resp_window", {31'd0, found}, 32'd1);
        STALL = 1'b0;
        Request_Alt_PC = 1'b1;
        Alt_PC = 32'hFFFFFFFC;
        tick();
        Request_Alt_PC = 1'b0;
        #1;
        chk("coinc_occupancy", {29'd0, occupancy}, 32'd0);
        chk("coinc_req_valid", {31'd0, mif.im_req_valid}, 32'd1);
        chk("coinc_req_addr", mif.im_req_addr, 32'hFFFFFFFC);
        tick();
        tick();
        chk("wrap_head_pc", Instr_PC_OUT, 32'hFFFFFFFC);
        chk("wrap_plus4", Instr_PC_Plus4, 32'h00000000);
        chk("wrap_req_valid", {31'd0, mif.im_req_valid}, 32'd1);
        chk("wrap_req_addr", mif.im_req_addr, 32'h00000000);

        // Reset mid-operation with 3 queued and one outstanding
        STALL = 1'b1;
        lat = 4;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (occupancy == 3'd3 && !mif.im_req_valid) found = 1'b1;
        end
        chk("find_three_busy", {31'd0, found}, 32'd1);
        mif.im_req_ready = 1'b0;
        RESET = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_occupancy", {29'd0, occupancy}, 32'd0);
        chk("mid_rst_instr", Instr1_OUT, 32'd0);
        chk("mid_rst_pc", Instr_PC_OUT, 32'd0);
        chk("mid_rst_plus4", Instr_PC_Plus4, 32'd0);
        chk("mid_rst_req_valid", {31'd0, mif.im_req_valid}, 32'd0);
        tick();
        RESET = 1'b1;
        #1;
        chk("post_rst_req_valid", {31'd0, mif.im_req_valid}, 32'd1);
        chk("post_rst_req_addr", mif.im_req_addr, 32'hBFC00000);
        repeat (4) tick();
        chk("late_resp_ignored", {29'd0, occupancy}, 32'd0);
        chk("late_resp_out_valid", {31'd0, out_valid}, 32'd0);
        mif.im_req_ready = 1'b1;
        STALL = 1'b0;
        lat = 2;
        repeat (12) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
